// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry look-ahead adder: digit width and FSM states.
package cla_pkg;
   localparam int DIGIT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/cla_digit_2b.sv
// 2-bit carry look-ahead digit: sum, carries and digit propagate/generate from a, b and carry-in.
// Purely combinational, no latency, no flow control.
module cla_digit_2b
   import cla_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               c,
   output logic [DIGIT_W-1:0] sum,
   output logic               cout,
   output logic               c1,
   output logic               p_d,
   output logic               g_d
);
   logic [DIGIT_W-1:0] p;
   logic [DIGIT_W-1:0] g;

   always_comb begin
      p      = a ^ b;
      g      = a & b;
      c1     = g[0] | (p[0] & c);
      sum[0] = p[0] ^ c;
      sum[1] = p[1] ^ c1;
      p_d    = p[1] & p[0];
      g_d    = g[1] | (p[1] & g[0]);
      cout   = g_d | (p_d & c);
   end
endmodule

// File: rtl/cla_serial_adder.sv
// Serial WIDTH-bit add/subtract, 2 bits per clock through one look-ahead digit; N+2 cycles per op.
// Result valid N edges after acceptance and held until out_ready; no request queueing.
module cla_serial_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_p,
   output logic             out_g
);
   localparam int N     = WIDTH / DIGIT_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               pacc_q, pacc_d;
   logic               gacc_q, gacc_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               res_p_q, res_p_d;
   logic               res_g_q, res_g_d;

   logic [DIGIT_W-1:0] dg_sum;
   logic               dg_cout;
   logic               dg_c1;
   logic               dg_p;
   logic               dg_g;

   // Operands shift right each digit, so the current digit is always in the low bits.
   cla_digit_2b u_digit (
      .a    (a_q[DIGIT_W-1:0]),
      .b    (b_q[DIGIT_W-1:0]),
      .c    (carry_q),
      .sum  (dg_sum),
      .cout (dg_cout),
      .c1   (dg_c1),
      .p_d  (dg_p),
      .g_d  (dg_g)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      pacc_d  = pacc_q;
      gacc_d  = gacc_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      res_p_d = res_p_q;
      res_g_d = res_g_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_sub ? ~in_b : in_b;
               carry_d = in_sub ? 1'b1 : in_cin;
               cnt_d   = '0;
               pacc_d  = 1'b1;
               gacc_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT_W;
            b_d     = b_q >> DIGIT_W;
            sum_d   = {dg_sum, sum_q[WIDTH-1:DIGIT_W]};
            carry_d = dg_cout;
            pacc_d  = pacc_q & dg_p;
            gacc_d  = dg_g | (dg_p & gacc_q);
            if (cnt_q == CNT_W'(N - 1)) begin
               cnt_d   = '0;
               cout_d  = dg_cout;
               ovf_d   = dg_c1 ^ dg_cout;
               res_p_d = pacc_q & dg_p;
               res_g_d = dg_g | (dg_p & gacc_q);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         pacc_q  <= 1'b0;
         gacc_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         res_p_q <= 1'b0;
         res_g_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         pacc_q  <= pacc_d;
         gacc_q  <= gacc_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         res_p_q <= res_p_d;
         res_g_q <= res_g_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;
   assign out_p     = res_p_q;
   assign out_g     = res_g_q;
endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed-vector bench for cla_serial_adder (WIDTH=32) with hand-computed expectations.
module tb_cla_serial_adder;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         out_p;
   logic         out_g;

   int total = 0;
   int bad   = 0;

   cla_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_p     (out_p),
      .out_g     (out_g)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operation while IDLE; returns just after the acceptance edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] sum, input logic cout,
                               input logic ovf, input logic p, input logic g);
      int cyc;
      wait_done(cyc);
      check({tag, "_lat"}, 64'(cyc), 64'd16);
      check({tag, "_sum"}, 64'(out_sum), 64'(sum));
      check({tag, "_cout"}, 64'(out_cout), 64'(cout));
      check({tag, "_ovf"}, 64'(out_ovf), 64'(ovf));
      check({tag, "_p"}, 64'(out_p), 64'(p));
      check({tag, "_g"}, 64'(out_g), 64'(g));
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int cyc;
      logic [W-1:0] held_sum;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(out_sum), 64'd0);
      check("rst_flags", 64'({out_cout, out_ovf, out_p, out_g}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("t1_busy", 64'(in_ready), 64'd0);
      check_result("t1", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
      handshake();
      check("t1_drop", 64'(out_valid), 64'd0);
      check("t1_idle", 64'(in_ready), 64'd1);
      check("t1_keep", 64'(out_sum), 64'd0);

      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      check_result("t2", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      handshake();

      issue(32'd5, 32'd7, 1'b0, 1'b1);
      check_result("t3a", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      handshake();
      issue(32'd5, 32'd7, 1'b1, 1'b1);
      check_result("t3b", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      handshake();

      issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
      check_result("t4", 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      handshake();

      // Back-pressure in DONE, then a held request taken right after the handshake.
      issue(32'd1, 32'd2, 1'b0, 1'b0);
      check_result("t5", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      held_sum = out_sum;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_hold_vld", 64'(out_valid), 64'd1);
         check("t5_hold_rdy", 64'(in_ready), 64'd0);
         check("t5_hold_sum", 64'(out_sum), 64'(held_sum));
      end
      in_a      = 32'd10;
      in_b      = 32'd20;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t5_rdy_after", 64'(in_ready), 64'd1);
      check("t5_vld_after", 64'(out_valid), 64'd0);
      tick();
      in_valid = 1'b0;
      check("t5_accepted", 64'(in_ready), 64'd0);
      check_result("t5b", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
      handshake();

      // Reset in the middle of a carry-heavy operation.
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      check("t6_running", 64'(out_valid), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_vld", 64'(out_valid), 64'd0);
      check("t6_rst_rdy", 64'(in_ready), 64'd1);
      tick();
      check("t6_rst_vld2", 64'(out_valid), 64'd0);
      check("t6_rst_sum", 64'(out_sum), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t6_no_pulse", 64'(out_valid), 64'd0);
      issue(32'd3, 32'd4, 1'b0, 1'b0);
      check_result("t6", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      handshake();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
